branch_tag_manager: RTL and testbench

Owns the branch tags (b_id one-hot / b_mask) and their recovery checkpoints. It is the other end of the branch-FU protocol. Dispatch allocates a tag per branch. The branch FU returns CLEAR/SQUASH resolutions, and this block registers them and broadcasts rem_br_task/rem_b_id to every mask holder (RS, FUs, ROB, LSQ), including the branch FU itself. On SQUASH it also supplies the saved checkpoint for front-end/map-table recovery.

---
 rtl/branch_tag_manager_pkg.sv | 22 ++
 rtl/branch_tag_manager_picker.sv | 21 ++
 rtl/branch_tag_manager.sv | 131 +++++++++++++
 tb/tb_branch_tag_manager.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_tag_manager_pkg.sv
// ============================================================================
// branch_tag_manager_pkg : shared branch-tag types and default sizes
// Rev 1.0
// ============================================================================
`default_nettype none

package branch_tag_manager_pkg;

    localparam int NUM_BR_DEF = 4;
    localparam int CKPT_W_DEF = 64;

    typedef logic [NUM_BR_DEF-1:0] br_mask_t;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        CLEAR   = 2'd1,
        SQUASH  = 2'd2
    } br_task_t;

endpackage

`default_nettype wire

// File: rtl/branch_tag_manager_picker.sv
// ============================================================================
// br_tag_picker : lowest-set-bit one-hot selector over a free vector
// Rev 1.0
// ============================================================================
`default_nettype none

module br_tag_picker #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] free_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic             any_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot_o = free_i & (~free_i + WIDTH'(1));
    assign any_o    = |free_i;

endmodule

`default_nettype wire

// File: rtl/branch_tag_manager.sv
// ============================================================================
// branch_tag_manager : allocates branch tags, tracks dependences/checkpoints,
// and broadcasts CLEAR/SQUASH resolutions to all mask holders.
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_tag_manager
    import branch_tag_manager_pkg::*;
#(
    parameter int NUM_BR = NUM_BR_DEF,
    parameter int CKPT_W = CKPT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_req,
    input  logic [CKPT_W-1:0] alloc_ckpt,
    output logic              alloc_gnt,
    output logic [NUM_BR-1:0] alloc_b_id,
    output logic [NUM_BR-1:0] cur_b_mask,
    output logic              full,
    input  logic              res_valid,
    input  br_task_t          res_task,
    input  logic [NUM_BR-1:0] res_b_id,
    output br_task_t          rem_br_task,
    output logic [NUM_BR-1:0] rem_b_id,
    output logic [CKPT_W-1:0] rec_ckpt
);

    logic [NUM_BR-1:0] valid_q, valid_d;
    logic [NUM_BR-1:0] dep_q  [NUM_BR];
    logic [NUM_BR-1:0] dep_d  [NUM_BR];
    logic [CKPT_W-1:0] ckpt_q [NUM_BR];
    logic [CKPT_W-1:0] ckpt_d [NUM_BR];
    br_task_t          rem_task_q, rem_task_d;
    logic [NUM_BR-1:0] rem_id_q, rem_id_d;
    logic [CKPT_W-1:0] rec_ckpt_q, rec_ckpt_d;

    logic [NUM_BR-1:0] w_pick;
    logic              w_any_free;
    logic              w_res_eff;
    logic              w_squash_req;
    logic [NUM_BR-1:0] w_younger;
    logic [NUM_BR-1:0] w_clr_mask;
    logic [NUM_BR-1:0] w_kill_mask;
    logic [CKPT_W-1:0] w_sel_ckpt;

    br_tag_picker #(.WIDTH(NUM_BR)) u_picker (
        .free_i   (~valid_q),
        .onehot_o (w_pick),
        .any_o    (w_any_free)
    );

    assign full         = ~w_any_free;
    assign w_squash_req = res_valid && (res_task == SQUASH);
    // A squash redirects dispatch, so nothing is granted in that cycle.
    assign alloc_gnt    = reset && alloc_req && w_any_free && !w_squash_req;
    assign alloc_b_id   = alloc_gnt ? w_pick : '0;
    assign w_res_eff    = res_valid && (res_task != NOTHING) && (|(res_b_id & valid_q));

    for (genvar j = 0; j < NUM_BR; j++) begin : g_younger
        assign w_younger[j] = valid_q[j] && (|(dep_q[j] & res_b_id));
    end

    always_comb begin
        w_sel_ckpt = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            w_sel_ckpt = w_sel_ckpt | (ckpt_q[i] & {CKPT_W{res_b_id[i]}});
        end
    end

    always_comb begin
        w_clr_mask  = '0;
        w_kill_mask = '0;
        if (w_res_eff) begin
            if (res_task == SQUASH) begin
                w_kill_mask = res_b_id | w_younger;
            end else begin
                w_kill_mask = res_b_id;
                w_clr_mask  = res_b_id;
            end
        end
        valid_d = (valid_q & ~w_kill_mask) | alloc_b_id;
        for (int i = 0; i < NUM_BR; i++) begin
            dep_d[i]  = w_kill_mask[i] ? '0 : (dep_q[i] & ~w_clr_mask);
            ckpt_d[i] = ckpt_q[i];
            if (alloc_b_id[i]) begin
                dep_d[i]  = valid_q & ~w_clr_mask;
                ckpt_d[i] = alloc_ckpt;
            end
        end
        rem_task_d = w_res_eff ? res_task : NOTHING;
        rem_id_d   = w_res_eff ? res_b_id : '0;
        rec_ckpt_d = (w_res_eff && (res_task == SQUASH)) ? w_sel_ckpt : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            rem_task_q <= NOTHING;
            rem_id_q   <= '0;
            rec_ckpt_q <= '0;
            for (int i = 0; i < NUM_BR; i++) begin
                dep_q[i]  <= '0;
                ckpt_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            rem_task_q <= rem_task_d;
            rem_id_q   <= rem_id_d;
            rec_ckpt_q <= rec_ckpt_d;
            for (int i = 0; i < NUM_BR; i++) begin
                dep_q[i]  <= dep_d[i];
                ckpt_q[i] <= ckpt_d[i];
            end
        end
    end

    assign cur_b_mask  = valid_q;
    assign rem_br_task = rem_task_q;
    assign rem_b_id    = rem_id_q;
    assign rec_ckpt    = rec_ckpt_q;

`ifndef SYNTHESIS
    a_res_onehot: assert property (@(posedge clock) disable iff (!reset)
        (res_valid && (res_task != NOTHING)) |-> $onehot(res_b_id));
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_tag_manager.sv
// ============================================================================
// tb_branch_tag_manager : table-driven vectors with a scoreboard queue for
// the registered outputs, plus a hand-written mid-operation reset sequence.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_branch_tag_manager;
    import branch_tag_manager_pkg::*;

    localparam int NB = 4;
    localparam int CW = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          alloc_req = 1'b0;
    logic [CW-1:0] alloc_ckpt = '0;
    logic          alloc_gnt;
    logic [NB-1:0] alloc_b_id;
    logic [NB-1:0] cur_b_mask;
    logic          full;
    logic          res_valid = 1'b0;
    br_task_t      res_task = NOTHING;
    logic [NB-1:0] res_b_id = '0;
    br_task_t      rem_br_task;
    logic [NB-1:0] rem_b_id;
    logic [CW-1:0] rec_ckpt;

    branch_tag_manager #(.NUM_BR(NB), .CKPT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_ckpt  (alloc_ckpt),
        .alloc_gnt   (alloc_gnt),
        .alloc_b_id  (alloc_b_id),
        .cur_b_mask  (cur_b_mask),
        .full        (full),
        .res_valid   (res_valid),
        .res_task    (res_task),
        .res_b_id    (res_b_id),
        .rem_br_task (rem_br_task),
        .rem_b_id    (rem_b_id),
        .rec_ckpt    (rec_ckpt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          req;
        logic [CW-1:0] ck;
        logic          rv;
        br_task_t      rt;
        logic [NB-1:0] rb;
        logic          e_gnt;
        logic [NB-1:0] e_bid;
        logic          e_full;
        logic [NB-1:0] e_mask;
        br_task_t      e_rt;
        logic [NB-1:0] e_rb;
        logic [CW-1:0] e_rc;
    } vec_t;

    typedef struct {
        logic [NB-1:0] mask;
        br_task_t      rt;
        logic [NB-1:0] rb;
        logic [CW-1:0] rc;
        int            idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic req, input logic [CW-1:0] ck, input logic rv,
                                input br_task_t rt, input logic [NB-1:0] rb,
                                input logic eg, input logic [NB-1:0] eb, input logic ef,
                                input logic [NB-1:0] em, input br_task_t ert,
                                input logic [NB-1:0] erb, input logic [CW-1:0] erc);
        vec_t v;
        v.req = req; v.ck = ck; v.rv = rv; v.rt = rt; v.rb = rb;
        v.e_gnt = eg; v.e_bid = eb; v.e_full = ef;
        v.e_mask = em; v.e_rt = ert; v.e_rb = erb; v.e_rc = erc;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clock);
        alloc_req  = v.req;
        alloc_ckpt = v.ck;
        res_valid  = v.rv;
        res_task   = v.rt;
        res_b_id   = v.rb;
        #1;
        chk($sformatf("v%0d alloc_gnt", idx),  64'(alloc_gnt),  64'(v.e_gnt));
        chk($sformatf("v%0d alloc_b_id", idx), 64'(alloc_b_id), 64'(v.e_bid));
        chk($sformatf("v%0d full", idx),       64'(full),       64'(v.e_full));
        e.mask = v.e_mask; e.rt = v.e_rt; e.rb = v.e_rb; e.rc = v.e_rc; e.idx = idx;
        sb.push_back(e);
        @(posedge clock);
        #1;
        alloc_req = 1'b0;
        res_valid = 1'b0;
        res_task  = NOTHING;
        res_b_id  = '0;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL v%0d scoreboard: actual=empty required=entry", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d cur_b_mask", e.idx),  64'(cur_b_mask),  64'(e.mask));
            chk($sformatf("v%0d rem_br_task", e.idx), 64'(rem_br_task), 64'(e.rt));
            chk($sformatf("v%0d rem_b_id", e.idx),    64'(rem_b_id),    64'(e.rb));
            chk($sformatf("v%0d rec_ckpt", e.idx),    rec_ckpt,         e.rc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with a request pending to prove the grant is gated.
        alloc_req = 1'b1;
        #1;
        chk("rst cur_b_mask",  64'(cur_b_mask),  64'(0));
        chk("rst rem_br_task", 64'(rem_br_task), 64'(NOTHING));
        chk("rst rem_b_id",    64'(rem_b_id),    64'(0));
        chk("rst rec_ckpt",    rec_ckpt,         64'(0));
        chk("rst full",        64'(full),        64'(0));
        chk("rst alloc_gnt",   64'(alloc_gnt),   64'(0));
        alloc_req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Fill, full-reject, full+CLEAR, then a squash that wipes all dependents.
        vecs.push_back(mk(1'b1, 64'hA,  1'b0, NOTHING, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0001, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b1, 64'hB,  1'b0, NOTHING, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0011, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b1, 64'hC,  1'b0, NOTHING, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0111, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b1, 64'hD,  1'b0, NOTHING, 4'b0000, 1'b1, 4'b1000, 1'b0, 4'b1111, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b1, 64'h5,  1'b0, NOTHING, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1111, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b1, 64'h6,  1'b1, CLEAR,   4'b0100, 1'b0, 4'b0000, 1'b1, 4'b1011, CLEAR,   4'b0100, 64'h0));
        vecs.push_back(mk(1'b1, 64'hE,  1'b0, NOTHING, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b1111, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b1, 64'h8,  1'b1, SQUASH,  4'b0001, 1'b0, 4'b0000, 1'b1, 4'b0000, SQUASH,  4'b0001, 64'hA));
        // Squash chain with a blocked allocation in the squash cycle.
        vecs.push_back(mk(1'b1, 64'hA,  1'b0, NOTHING, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0001, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b1, 64'hB,  1'b0, NOTHING, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0011, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b1, 64'hC,  1'b0, NOTHING, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0111, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b1, 64'hF,  1'b1, SQUASH,  4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0001, SQUASH,  4'b0010, 64'hB));
        vecs.push_back(mk(1'b0, 64'h0,  1'b0, NOTHING, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001, NOTHING, 4'b0000, 64'h0));
        // Stale / ignored resolves.
        vecs.push_back(mk(1'b0, 64'h0,  1'b1, SQUASH,  4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0001, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b1, 64'h11, 1'b0, NOTHING, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0011, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b0, 64'h0,  1'b0, CLEAR,   4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0011, NOTHING, 4'b0000, 64'h0));
        // CLEAR drops the bit from dependents, so a later squash spares them.
        vecs.push_back(mk(1'b0, 64'h0,  1'b1, CLEAR,   4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0010, CLEAR,   4'b0001, 64'h0));
        vecs.push_back(mk(1'b1, 64'h22, 1'b0, NOTHING, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0011, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b0, 64'h0,  1'b1, SQUASH,  4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0010, SQUASH,  4'b0001, 64'h22));
        vecs.push_back(mk(1'b0, 64'h0,  1'b1, SQUASH,  4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, SQUASH,  4'b0010, 64'h11));
        vecs.push_back(mk(1'b1, 64'h33, 1'b0, NOTHING, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0001, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b0, 64'h0,  1'b1, NOTHING, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0001, NOTHING, 4'b0000, 64'h0));
        // Alloc alongside a CLEAR: new tag must not depend on the cleared one.
        vecs.push_back(mk(1'b1, 64'h44, 1'b1, CLEAR,   4'b0001, 1'b1, 4'b0010, 1'b0, 4'b0010, CLEAR,   4'b0001, 64'h0));
        vecs.push_back(mk(1'b1, 64'h55, 1'b0, NOTHING, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0011, NOTHING, 4'b0000, 64'h0));
        vecs.push_back(mk(1'b0, 64'h0,  1'b1, SQUASH,  4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0010, SQUASH,  4'b0001, 64'h55));
        vecs.push_back(mk(1'b0, 64'h0,  1'b1, SQUASH,  4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, SQUASH,  4'b0010, 64'h44));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Mid-operation reset while a squash broadcast is on the outputs.
        apply(mk(1'b1, 64'h1, 1'b0, NOTHING, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0001, NOTHING, 4'b0000, 64'h0), 100);
        apply(mk(1'b1, 64'h2, 1'b0, NOTHING, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0011, NOTHING, 4'b0000, 64'h0), 101);
        apply(mk(1'b0, 64'h0, 1'b1, SQUASH,  4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0001, SQUASH,  4'b0010, 64'h2), 102);
        alloc_req = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst cur_b_mask",  64'(cur_b_mask),  64'(0));
        chk("midrst rem_br_task", 64'(rem_br_task), 64'(NOTHING));
        chk("midrst rem_b_id",    64'(rem_b_id),    64'(0));
        chk("midrst rec_ckpt",    rec_ckpt,         64'(0));
        chk("midrst full",        64'(full),        64'(0));
        chk("midrst alloc_gnt",   64'(alloc_gnt),   64'(0));
        alloc_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        apply(mk(1'b1, 64'h77, 1'b0, NOTHING, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0001, NOTHING, 4'b0000, 64'h0), 103);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
